syn_fifo_rd_engine: RTL and testbench

- Read-side engine for the synchronous FIFO: the consumer at the far end of the FIFO from the writer.
- On a burst command it pops the requested number of entries from the FIFO read port and absorbs the FIFO's 1-cycle read latency.
- Popped data goes out on a valid/ready stream through a 2-entry skid buffer, tagged with the FIFO slot index it came from.
- Sits between syn_fifo and any downstream consumer (DMA, checker, serializer).

---
 rtl/syn_fifo_rd_engine.sv | 165 ++++++++++++++++
 tb/tb_syn_fifo_rd_engine.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/syn_fifo_rd_engine.sv
// Read-side burst engine for syn_fifo: pops N entries, absorbs the read
// latency and streams words with their slot index through a 2-entry skid.
module syn_fifo_rd_engine #(
  parameter  int FIFO_ENTRIES = 16,
  parameter  int DATA_WIDTH   = 8,
  localparam int IW = $clog2(FIFO_ENTRIES),
  localparam int CW = IW + 1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  burst_start,
  input  logic [CW-1:0]         burst_len,
  output logic                  busy,
  output logic                  done,
  output logic [CW-1:0]         rd_count,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [IW-1:0]         m_index
);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CW-1:0]         remaining;
  logic [IW-1:0]         r_index;
  logic [IW-1:0]         inflight_tag;
  logic                  inflight;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] head_data;
  logic [DATA_WIDTH-1:0] tail_data;
  logic [IW-1:0]         head_idx;
  logic [IW-1:0]         tail_idx;
  logic                  vld;
  logic                  deq;
  logic                  pop;
  logic [2:0]            load;

  assign vld  = (occ != 2'd0);
  assign deq  = vld && m_ready;
  // Slots already committed once this cycle's dequeue is accounted for
  assign load = {1'b0, occ} + {2'b0, inflight} - {2'b0, deq};
  assign pop  = (state == DRAIN) && !fifo_empty
             && (remaining != '0) && (load < 3'd2);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (burst_start) begin
          state_nxt = (burst_len != '0) ? DRAIN : DONE;
        end
      end
      DRAIN: begin
        if (pop && remaining == CW'(1)) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (!inflight && occ == 2'd0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    done       = (state == DONE);
    fifo_rd_en = pop;
    m_valid    = vld;
    m_data     = head_data;
    m_index    = head_idx;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      remaining    <= '0;
      rd_count     <= '0;
      r_index      <= '0;
      inflight     <= 1'b0;
      inflight_tag <= '0;
    end else begin
      if (state == IDLE && burst_start) begin
        remaining <= burst_len;
        rd_count  <= '0;
      end else if (pop) begin
        remaining <= remaining - CW'(1);
        rd_count  <= rd_count + CW'(1);
      end
      inflight <= pop;
      if (pop) begin
        inflight_tag <= r_index;
        r_index      <= r_index + IW'(1);
      end
    end
  end

  // Skid buffer: head drives the stream, tail holds the overflow word
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      occ       <= 2'd0;
      head_data <= '0;
      head_idx  <= '0;
      tail_data <= '0;
      tail_idx  <= '0;
    end else begin
      unique case ({inflight, deq})
        2'b10: begin
          if (occ == 2'd0) begin
            head_data <= fifo_rdata;
            head_idx  <= inflight_tag;
          end else begin
            tail_data <= fifo_rdata;
            tail_idx  <= inflight_tag;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head_data <= tail_data;
          head_idx  <= tail_idx;
          occ       <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            head_data <= fifo_rdata;
            head_idx  <= inflight_tag;
          end else begin
            head_data <= tail_data;
            head_idx  <= tail_idx;
            tail_data <= fifo_rdata;
            tail_idx  <= inflight_tag;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_syn_fifo_rd_engine.sv
// Bench for syn_fifo_rd_engine: behavioural FIFO + scoreboard of
// {data, slot}, burst vector table, random bursts and corner sequences.
module tb_syn_fifo_rd_engine;

  localparam int N  = 16;
  localparam int DW = 8;
  localparam int IW = 4;
  localparam int CW = 5;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rdata;
  logic          burst_start = 1'b0;
  logic [CW-1:0] burst_len = '0;
  logic          busy;
  logic          done;
  logic [CW-1:0] rd_count;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [IW-1:0] m_index;

  always #5 sys_clk = ~sys_clk;

  syn_fifo_rd_engine #(.FIFO_ENTRIES(N), .DATA_WIDTH(DW)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_rdata (fifo_rdata),
    .burst_start(burst_start),
    .burst_len  (burst_len),
    .busy       (busy),
    .done       (done),
    .rd_count   (rd_count),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_index    (m_index)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [IW-1:0] i;
  } word_t;

  typedef struct {
    int len;
    int prefill;
    int period;
    int rmode;
    int exp_run;
  } vec_t;

  // Behavioural FIFO with 1-cycle read latency
  logic [DW-1:0] mem [N];
  int            fcount = 0;
  logic [IW-1:0] wp = '0;
  logic [IW-1:0] rp = '0;
  logic          push = 1'b0;
  logic [DW-1:0] push_data = '0;
  word_t         exp_q [$];

  assign fifo_empty = (fcount == 0);

  always @(posedge sys_clk) begin
    if (sys_rst) begin
      fcount     <= 0;
      wp         <= '0;
      rp         <= '0;
      fifo_rdata <= '0;
      exp_q.delete();
    end else begin
      if (fifo_rd_en && fcount > 0) begin
        fifo_rdata <= mem[rp];
        rp         <= rp + 1'b1;
      end
      if (push) begin
        mem[wp] <= push_data;
        wp      <= wp + 1'b1;
        exp_q.push_back('{push_data, wp});
      end
      fcount <= fcount + int'(push) - int'(fifo_rd_en && fcount > 0);
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int            pops = 0;
  int            accs = 0;
  int            dones = 0;
  int            outst = 0;
  int            rd_run = 0;
  int            acc_run = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] pdata = '0;
  logic [IW-1:0] pidx = '0;

  always @(negedge sys_clk) begin
    if (sys_rst) begin
      prev_stall = 1'b0;
      outst      = 0;
      rd_run     = 0;
      acc_run    = 0;
    end else begin
      if (fifo_rd_en) begin
        chk("pop_when_empty", 32'(fifo_empty), 0);
        pops++;
        outst++;
        rd_run++;
      end else begin
        rd_run = 0;
      end
      if (prev_stall) begin
        chk("stall_valid", 32'(m_valid), 1);
        chk("stall_data", 32'(m_data), 32'(pdata));
        chk("stall_index", 32'(m_index), 32'(pidx));
      end
      if (m_valid && m_ready) begin
        chk("spurious_word", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          chk("m_data", 32'(m_data), 32'(exp_q[0].d));
          chk("m_index", 32'(m_index), 32'(exp_q[0].i));
          void'(exp_q.pop_front());
        end
        accs++;
        outst--;
        acc_run++;
      end else begin
        acc_run = 0;
      end
      if (outst > 2) chk("outstanding", 32'(outst), 2);
      if (done) dones++;
      prev_stall = m_valid && !m_ready;
      pdata      = m_data;
      pidx       = m_index;
    end
  end

  int wctr = 0;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    push      = 1'b1;
    push_data = d;
    tick();
    push = 1'b0;
  endtask

  task automatic run_burst(input vec_t v);
    int p0, a0, d0, to_push, maxrd, maxacc;
    bit seen;
    for (int i = 0; i < v.prefill; i++) begin
      push_word(8'(wctr));
      wctr++;
    end
    p0 = pops;
    a0 = accs;
    d0 = dones;
    to_push = v.len - v.prefill;
    maxrd = 0;
    maxacc = 0;
    burst_start = 1'b1;
    burst_len   = CW'(v.len);
    tick();
    burst_start = 1'b0;
    seen = 0;
    for (int cyc = 0; cyc < 2000 && !seen; cyc++) begin
      case (v.rmode)
        0:       m_ready = 1'b1;
        1:       m_ready = (cyc % 3 == 0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      push = 1'b0;
      if (to_push > 0 && v.period > 0 && cyc % v.period == 0) begin
        push      = 1'b1;
        push_data = 8'(wctr);
        wctr++;
        to_push--;
      end
      tick();
      if (rd_run > maxrd) maxrd = rd_run;
      if (acc_run > maxacc) maxacc = acc_run;
      if (dones != d0) seen = 1;
    end
    push = 1'b0;
    chk("done_seen", 32'(seen), 1);
    tick();
    tick();
    chk("done_count", 32'(dones - d0), 1);
    chk("pops", 32'(pops - p0), 32'(v.len));
    chk("accepts", 32'(accs - a0), 32'(v.len));
    chk("rd_count", 32'(rd_count), 32'(v.len));
    chk("busy_after", 32'(busy), 0);
    if (v.exp_run != 0) begin
      chk("rd_en_run", 32'(maxrd), 32'(v.exp_run));
      chk("accept_run", 32'(maxacc), 32'(v.exp_run));
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_m_valid"}, 32'(m_valid), 0);
    chk({tag, "_rd_en"}, 32'(fifo_rd_en), 0);
    chk({tag, "_rd_count"}, 32'(rd_count), 0);
    chk({tag, "_m_data"}, 32'(m_data), 0);
    chk({tag, "_m_index"}, 32'(m_index), 0);
  endtask

  vec_t tbl [7];

  initial begin
    int d0, p0;
    bit got;
    vec_t rv;

    tbl[0] = '{len: 16, prefill: 16, period: 0, rmode: 0, exp_run: 16};
    tbl[1] = '{len: 8,  prefill: 8,  period: 0, rmode: 0, exp_run: 0};
    tbl[2] = '{len: 8,  prefill: 8,  period: 0, rmode: 0, exp_run: 0};
    tbl[3] = '{len: 8,  prefill: 8,  period: 0, rmode: 0, exp_run: 0};
    tbl[4] = '{len: 4,  prefill: 0,  period: 3, rmode: 0, exp_run: 0};
    tbl[5] = '{len: 6,  prefill: 6,  period: 0, rmode: 1, exp_run: 0};
    tbl[6] = '{len: 5,  prefill: 2,  period: 2, rmode: 2, exp_run: 0};

    tick();
    tick();
    chk_reset_outputs("reset");
    sys_rst = 1'b0;
    tick();

    // Single word: latency from the start edge to m_valid
    push_word(8'h05);
    d0 = dones;
    m_ready     = 1'b1;
    burst_start = 1'b1;
    burst_len   = CW'(1);
    tick();
    burst_start = 1'b0;
    chk("lat_rd_en", 32'(fifo_rd_en), 1);
    chk("lat_valid_n1", 32'(m_valid), 0);
    tick();
    chk("lat_valid_n2", 32'(m_valid), 0);
    tick();
    chk("lat_valid_n3", 32'(m_valid), 1);
    chk("lat_data", 32'(m_data), 32'h05);
    chk("lat_index", 32'(m_index), 0);
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      tick();
      if (dones != d0) got = 1;
    end
    chk("single_done", 32'(got), 1);
    tick();
    chk("single_done_once", 32'(dones - d0), 1);
    chk("single_rd_count", 32'(rd_count), 1);
    chk("single_busy", 32'(busy), 0);

    // Realign the write counter so the full burst carries 0x00..0x0F
    wctr = 0;
    for (int t = 0; t < 7; t++) begin
      run_burst(tbl[t]);
    end

    for (int r = 0; r < 20; r++) begin
      rv.len     = int'($urandom_range(0, N));
      rv.prefill = int'($urandom_range(0, rv.len));
      rv.period  = int'($urandom_range(1, 4));
      rv.rmode   = 2;
      rv.exp_run = 0;
      run_burst(rv);
    end

    // Zero-length burst
    d0 = dones;
    p0 = pops;
    burst_start = 1'b1;
    burst_len   = '0;
    tick();
    burst_start = 1'b0;
    @(negedge sys_clk);
    chk("len0_done", 32'(done), 1);
    chk("len0_busy", 32'(busy), 1);
    chk("len0_rd_en", 32'(fifo_rd_en), 0);
    tick();
    @(negedge sys_clk);
    chk("len0_done_drop", 32'(done), 0);
    chk("len0_busy_drop", 32'(busy), 0);
    chk("len0_pops", 32'(pops - p0), 0);
    chk("len0_done_once", 32'(dones - d0), 1);
    tick();

    // Reset in the middle of a burst, then a fresh burst
    for (int i = 0; i < 8; i++) begin
      push_word(8'(8'h40 + i));
    end
    d0 = dones;
    p0 = pops;
    m_ready     = 1'b1;
    burst_start = 1'b1;
    burst_len   = CW'(8);
    tick();
    burst_start = 1'b0;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      tick();
      if (pops - p0 >= 3) got = 1;
    end
    chk("midrst_pops_seen", 32'(got), 1);
    sys_rst = 1'b1;
    tick();
    chk_reset_outputs("midrst");
    sys_rst = 1'b0;
    chk("midrst_no_done", 32'(dones - d0), 0);
    tick();
    rv = '{len: 2, prefill: 2, period: 0, rmode: 0, exp_run: 0};
    run_burst(rv);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
